term_writer: RTL and testbench

- Upstream neighbour of the character buffer. Consumes a byte stream from the host/UART receiver over a valid/ready handshake.
- Interprets printable characters and basic control codes, tracks the cursor, and issues single-port write cycles (address, data, write-enable) into the character buffer.
- Implements scrolling by rotating a display origin row, published to the display reader, and blanking the newly exposed row.

---
 rtl/term_writer.sv | 195 +++++++++++++++++++
 tb/tb_term_writer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/term_writer.sv
// ============================================================================
// Module   : term_writer
// Purpose  : Byte-stream terminal front end: cursor tracking, character
//            buffer writes and origin-row scrolling. Optional feature macro
//            TERM_WRITER_AUTOWRAP_EN enables wrap-to-next-line at last column.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module term_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 24,
  parameter int ADDR_W = 11,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 5
) (
  input  logic              pclk,
  input  logic              clr_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_din,
  output logic              buf_wen,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  cur_row,
  output logic [ROW_W-1:0]  first_row,
  output logic              busy
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WRITE, S_CLEAR} state_t;

  localparam logic [ADDR_W:0]   c_cells    = (ADDR_W+1)'(ROWS*COLS);
  localparam logic [ADDR_W:0]   c_cols_cnt = (ADDR_W+1)'(COLS);
  localparam logic [ADDR_W-1:0] c_cols_a   = ADDR_W'(COLS);
  localparam logic [ROW_W:0]    c_rows_w   = (ROW_W+1)'(ROWS);
  localparam logic [COL_W-1:0]  c_last_col = COL_W'(COLS-1);
  localparam logic [ROW_W-1:0]  c_last_row = ROW_W'(ROWS-1);
  localparam logic [7:0]        c_space    = 8'h20;

  state_t              r_state;
  logic [ADDR_W:0]     r_cnt;
  logic                r_clr_pend;
  logic [ADDR_W-1:0]   r_clr_base;
  logic                r_ready;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_din;
  logic                r_wen;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [ROW_W-1:0]    r_first;
  logic                r_busy;

  logic [ROW_W:0]      w_sum;
  logic [ROW_W:0]      w_phys;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [ADDR_W-1:0]   w_clr_base;
  logic [ROW_W-1:0]    w_first_nxt;
  logic                w_printable;

  // Logical cursor row maps onto the rotated physical buffer row.
  always_comb begin
    w_sum       = {1'b0, r_first} + {1'b0, r_row};
    w_phys      = (w_sum >= c_rows_w) ? (w_sum - c_rows_w) : w_sum;
    w_wr_addr   = ADDR_W'(w_phys) * c_cols_a + ADDR_W'(r_col);
    w_clr_base  = ADDR_W'(r_first) * c_cols_a;
    w_first_nxt = (r_first == c_last_row) ? '0 : r_first + ROW_W'(1);
    w_printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
  end

  always_ff @(posedge pclk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= S_INIT;
      r_cnt      <= '0;
      r_clr_pend <= 1'b0;
      r_clr_base <= '0;
      r_ready    <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_wen      <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_first    <= '0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_cnt == c_cells) begin
            r_wen   <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wen  <= 1'b1;
            r_din  <= c_space;
            r_addr <= r_cnt[ADDR_W-1:0];
            r_cnt  <= r_cnt + (ADDR_W+1)'(1);
          end
        end

        S_IDLE: begin
          r_wen <= 1'b0;
          if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (in_valid) begin
            r_ready <= 1'b0;
            if (w_printable) begin
              r_state <= S_WRITE;
              r_wen   <= 1'b1;
              r_din   <= in_data;
              r_addr  <= w_wr_addr;
              if (r_col != c_last_col) begin
                r_col <= r_col + COL_W'(1);
              end else begin
`ifdef TERM_WRITER_AUTOWRAP_EN
                // Wrap performs a full line feed; any clear is deferred
                // until the character write cycle has gone out.
                r_col <= '0;
                if (r_row != c_last_row) begin
                  r_row <= r_row + ROW_W'(1);
                end else begin
                  r_first    <= w_first_nxt;
                  r_clr_pend <= 1'b1;
                  r_clr_base <= w_clr_base;
                end
`endif
              end
            end else begin
              case (in_data)
                8'h0D: r_col <= '0;
                8'h08: if (r_col != '0) r_col <= r_col - COL_W'(1);
                8'h0A: begin
                  if (r_row != c_last_row) begin
                    r_row <= r_row + ROW_W'(1);
                  end else begin
                    r_first <= w_first_nxt;
                    r_state <= S_CLEAR;
                    r_busy  <= 1'b1;
                    r_wen   <= 1'b1;
                    r_din   <= c_space;
                    r_addr  <= w_clr_base;
                    r_cnt   <= (ADDR_W+1)'(1);
                  end
                end
                default: ;
              endcase
            end
          end
        end

        S_WRITE: begin
          if (r_clr_pend) begin
            r_clr_pend <= 1'b0;
            r_state    <= S_CLEAR;
            r_busy     <= 1'b1;
            r_wen      <= 1'b1;
            r_din      <= c_space;
            r_addr     <= r_clr_base;
            r_cnt      <= (ADDR_W+1)'(1);
          end else begin
            r_wen   <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        S_CLEAR: begin
          if (r_cnt == c_cols_cnt) begin
            r_wen   <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt + (ADDR_W+1)'(1);
          end
        end

        default: r_state <= S_INIT;
      endcase
    end
  end

  assign in_ready  = r_ready;
  assign buf_addr  = r_addr;
  assign buf_din   = r_din;
  assign buf_wen   = r_wen;
  assign cur_col   = r_col;
  assign cur_row   = r_row;
  assign first_row = r_first;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_term_writer.sv
// ============================================================================
// Module   : tb_term_writer
// Purpose  : Scoreboard bench for term_writer with a screen-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_term_writer;

  localparam int COLS = 80;
  localparam int ROWS = 24;

  logic        pclk = 1'b0;
  logic        clr_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] buf_addr;
  logic [7:0]  buf_din;
  logic        buf_wen;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic [4:0]  first_row;
  logic        busy;

  term_writer dut (
    .pclk      (pclk),
    .clr_n     (clr_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .buf_addr  (buf_addr),
    .buf_din   (buf_din),
    .buf_wen   (buf_wen),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .first_row (first_row),
    .busy      (busy)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;
  int m_row, m_col, m_first;
  logic [18:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every write cycle must match the oldest expected write.
  always @(negedge pclk) begin
    logic [18:0] e;
    if (clr_n && buf_wen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wen", int'(buf_addr), -1);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(buf_addr), int'(e[18:8]));
        chk("wr_din", int'(buf_din), int'(e[7:0]));
        chk("ready_during_write", int'(in_ready), 0);
      end
    end
  end

  task automatic model_reset();
    m_row = 0; m_col = 0; m_first = 0;
    for (int a = 0; a < ROWS*COLS; a++) exp_q.push_back({11'(a), 8'h20});
  endtask

  task automatic model_lf();
    if (m_row < ROWS-1) begin
      m_row++;
    end else begin
      for (int c = 0; c < COLS; c++) exp_q.push_back({11'(m_first*COLS + c), 8'h20});
      m_first = (m_first + 1) % ROWS;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({11'(((m_first + m_row) % ROWS) * COLS + m_col), b});
      if (m_col < COLS-1) begin
        m_col++;
      end else begin
`ifdef TERM_WRITER_AUTOWRAP_EN
        m_col = 0;
        model_lf();
`endif
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0A) begin
      model_lf();
    end
  endtask

  task automatic xfer(input logic [7:0] b);
    int t = 0;
    @(negedge pclk);
    while (!in_ready && t < 5000) begin
      @(negedge pclk);
      t++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = b;
    model_byte(b);
    @(posedge pclk);
    #1 in_valid = 1'b0;
  endtask

  task automatic settle();
    int t = 0;
    @(negedge pclk);
    while (!(in_ready && !busy) && t < 5000) begin
      @(negedge pclk);
      t++;
    end
    if (!(in_ready && !busy)) chk("idle_timeout", 0, 1);
    chk("cur_col", int'(cur_col), m_col);
    chk("cur_row", int'(cur_row), m_row);
    chk("first_row", int'(first_row), m_first);
    chk("writes_drained", exp_q.size(), 0);
  endtask

  task automatic send(input logic [7:0] b);
    xfer(b);
    settle();
  endtask

  task automatic chk_reset_vals();
    chk("rst_wen", int'(buf_wen), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_addr", int'(buf_addr), 0);
    chk("rst_din", int'(buf_din), 0);
    chk("rst_col", int'(cur_col), 0);
    chk("rst_row", int'(cur_row), 0);
    chk("rst_first", int'(first_row), 0);
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    logic [7:0] b;
    if (r < 55)      b = 8'(8'h20 + $urandom_range(0, 94));
    else if (r < 63) b = 8'h0D;
    else if (r < 71) b = 8'h08;
    else if (r < 88) b = 8'h0A;
    else if (r < 94) begin
      b = 8'($urandom_range(0, 31));
      if (b == 8'h08 || b == 8'h0A || b == 8'h0D) b = 8'h07;
    end else         b = 8'($urandom_range(127, 255));
    return b;
  endfunction

  initial begin
    #23;
    chk_reset_vals();
    model_reset();
    @(negedge pclk);
    clr_n = 1'b1;
    settle();

    // First printable: one write at origin, ready low for one cycle.
    xfer(8'h41);
    @(negedge pclk);
    chk("ready_low_after_xfer", int'(in_ready), 0);
    @(negedge pclk);
    chk("ready_back_high", int'(in_ready), 1);
    settle();

    // Control codes around (row 2, col 5).
    send(8'h0D); send(8'h0A); send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61);
    send(8'h08); send(8'h0D); send(8'h0A); send(8'h07);

    // Last column at row 4.
    send(8'h0D); send(8'h0A);
    for (int i = 0; i < COLS-1; i++) send(8'h62);
    send(8'h5A);
    send(8'h5A);

    // Scroll from the bottom row, then write at the new bottom.
    while (m_row < ROWS-1) send(8'h0A);
    send(8'h0A);
    send(8'h0D);
    send(8'h42);
    // Enough further scrolls to wrap the origin row through zero.
    for (int i = 0; i < ROWS+1; i++) send(8'h0A);

    for (int i = 0; i < 300; i++) send(rand_byte());

    // Reset in the middle of a clear.
    while (m_row < ROWS-1) send(8'h0A);
    xfer(8'h0A);
    repeat (39) @(posedge pclk);
    #2 clr_n = 1'b0;
    #1;
    chk_reset_vals();
    exp_q.delete();
    model_reset();
    @(negedge pclk);
    clr_n = 1'b1;
    settle();
    send(8'h43);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
